// File: rtl/cnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_layer_sequencer
//
// Purpose:
//   Runs a two-layer CNN pass: pulses layer 1 to start, counts its output
//   feature-map writes into the shared memory, checks that exactly OFM_WORDS
//   words arrived when layer 1 reports done, then hands the shared memory to
//   layer 2, pulses it to start and waits for its completion. Either run phase
//   is bounded by a cycle timeout. Any count mismatch or timeout parks the
//   block in ERROR until a new start request.
//
// Ports:
//   clk            single clock, all state changes on the rising edge
//   rst            asynchronous active-low reset
//   start          run request (accepted in IDLE and ERROR)
//   l1_done        layer-1 completion
//   l1_ofm_wr_en   layer-1 OFM write strobe
//   l1_wr_addr     layer-1 OFM write address
//   l2_done        layer-2 completion
//   l2_sel_mem     layer-2 requests the shared memory
//   l2_rd_addr     layer-2 read address
//   l1_start       one-cycle layer-1 start pulse
//   l2_start       one-cycle layer-2 start pulse
//   mem_addr       shared-memory address
//   mem_wr_en      shared-memory write enable
//   mem_owner      shared-memory owner (0 = layer 1, 1 = layer 2)
//   ofm_count      layer-1 writes accepted in the current run (saturates)
//   busy           high in every state except IDLE and ERROR
//   done           one-cycle run-complete pulse
//   error          high while parked in ERROR
// -----------------------------------------------------------------------------
module cnn_layer_sequencer #(
  parameter int OFM_WORDS      = 172,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       l1_done,
  input  logic       l1_ofm_wr_en,
  input  logic [7:0] l1_wr_addr,
  input  logic       l2_done,
  input  logic       l2_sel_mem,
  input  logic [7:0] l2_rd_addr,
  output logic       l1_start,
  output logic       l2_start,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic       mem_owner,
  output logic [7:0] ofm_count,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_L1_START = 3'd1;
  localparam logic [2:0] S_L1_RUN   = 3'd2;
  localparam logic [2:0] S_L2_START = 3'd3;
  localparam logic [2:0] S_L2_RUN   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;

  // Timer wide enough to hold TIMEOUT_CYCLES itself.
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic [7:0]    r_count;
  logic [7:0]    w_count_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [TW-1:0] w_timer_inc;
  logic          w_timer_hit;
  logic [8:0]    w_count_sum;
  logic          w_words_ok;
  logic          w_in_l1_run;
  logic          w_in_l2_run;

  assign w_in_l1_run = (r_state == S_L1_RUN);
  assign w_in_l2_run = (r_state == S_L2_RUN);

  // The timeout fires on the cycle whose increment reaches TIMEOUT_CYCLES,
  // so a phase gets exactly TIMEOUT_CYCLES cycles in its run state.
  assign w_timer_inc = r_timer + TW'(1);
  assign w_timer_hit = (w_timer_inc >= TW'(TIMEOUT_CYCLES));

  // A write landing in the same cycle as l1_done still counts toward the check.
  assign w_count_sum = {1'b0, r_count} + {8'd0, l1_ofm_wr_en};
  assign w_words_ok  = (w_count_sum == 9'(OFM_WORDS));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_next = S_L1_START;
      S_L1_START: w_state_next = S_L1_RUN;
      S_L1_RUN: begin
        // Completion outranks a coincident timeout.
        if (l1_done)          w_state_next = w_words_ok ? S_L2_START : S_ERROR;
        else if (w_timer_hit) w_state_next = S_ERROR;
      end
      S_L2_START: w_state_next = S_L2_RUN;
      S_L2_RUN: begin
        if (l2_done)          w_state_next = S_DONE;
        else if (w_timer_hit) w_state_next = S_ERROR;
      end
      S_DONE:     w_state_next = S_IDLE;
      S_ERROR:    if (start) w_state_next = S_L1_START;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    if (w_state_next == S_L1_START && r_state != S_L1_START) begin
      w_count_next = 8'd0;
    end else if (w_in_l1_run && l1_ofm_wr_en && r_count != 8'hFF) begin
      w_count_next = r_count + 8'd1;
    end
  end

  // Run states are only entered from their start states, so clearing there
  // restarts the timer on every entry.
  always_comb begin
    w_timer_next = '0;
    if (w_in_l1_run || w_in_l2_run) w_timer_next = w_timer_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= 8'd0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_timer <= w_timer_next;
    end
  end

  // Outputs decode the registered state, so reset clears them at once.
  assign l1_start  = (r_state == S_L1_START);
  assign l2_start  = (r_state == S_L2_START);
  assign mem_owner = (r_state == S_L2_START) || w_in_l2_run;
  assign mem_wr_en = w_in_l1_run && l1_ofm_wr_en;
  assign mem_addr  = w_in_l1_run                ? l1_wr_addr :
                     (w_in_l2_run && l2_sel_mem) ? l2_rd_addr : 8'd0;
  assign ofm_count = r_count;
  assign busy      = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign done      = (r_state == S_DONE);
  assign error     = (r_state == S_ERROR);

endmodule

// File: doc/cnn_layer_sequencer.md
CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 SHALL have parameter OFM_WORDS, default 172: exact number of layer-1 OFM writes expected per run.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum cycles allowed in either run state.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: run request, sampled in IDLE and ERROR only.
REQ-006 SHALL have port l1_done, input, 1: layer-1 completion.
REQ-007 SHALL have port l1_ofm_wr_en, input, 1: layer-1 OFM write strobe.
REQ-008 SHALL have port l1_wr_addr, input, 8: layer-1 OFM write address.
REQ-009 SHALL have port l2_done, input, 1: layer-2 completion.
REQ-010 SHALL have port l2_sel_mem, input, 1: layer-2 requests the shared memory.
REQ-011 SHALL have port l2_rd_addr, input, 8: layer-2 read address.
REQ-012 SHALL have port l1_start, output, 1: one-cycle layer-1 start pulse.
REQ-013 SHALL have port l2_start, output, 1: one-cycle layer-2 start pulse.
REQ-014 SHALL have port mem_addr, output, 8: shared-memory address.
REQ-015 SHALL have port mem_wr_en, output, 1: shared-memory write enable.
REQ-016 SHALL have port mem_owner, output, 1: memory owner, 0 = layer 1, 1 = layer 2.
REQ-017 SHALL have port ofm_count, output, 8: accepted layer-1 writes in the current run.
REQ-018 SHALL have ports busy, done and error, outputs, 1 bit each: status.

Function
REQ-019 SHALL implement a registered FSM with states IDLE, L1_START, L1_RUN, L2_START, L2_RUN, DONE and ERROR.
REQ-020 SHALL take IDLE -> L1_START on start=1; start SHALL be ignored in every other state except ERROR.
REQ-021 SHALL assert l1_start for exactly the L1_START cycle, then go to L1_RUN.
REQ-022 SHALL, in L1_RUN, increment ofm_count on each l1_ofm_wr_en=1 cycle, saturating at 255.
REQ-023 SHALL, in L1_RUN with l1_done=1, compare the count including a same-cycle write (ofm_count + l1_ofm_wr_en) against OFM_WORDS: equal -> L2_START, otherwise -> ERROR.
REQ-024 SHALL assert l2_start for exactly the L2_START cycle, then go to L2_RUN.
REQ-025 SHALL go L2_RUN -> DONE on l2_done=1; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-026 SHALL clear the timeout counter on entry to L1_RUN and L2_RUN and increment it each cycle in those states; at count TIMEOUT_CYCLES it SHALL go to ERROR.
REQ-027 SHALL give priority to the done input (l1_done or l2_done) when it coincides with a timeout in the same cycle.
REQ-028 SHALL hold error=1 in ERROR; start=1 there SHALL clear error and go to L1_START.
REQ-029 SHALL clear ofm_count on the transition into L1_START, and hold it otherwise outside L1_RUN.
REQ-030 SHALL drive mem_owner=1 in L2_START and L2_RUN, and 0 in all other states.
REQ-031 SHALL drive mem_wr_en = l1_ofm_wr_en in L1_RUN, and 0 in all other states; writes outside L1_RUN SHALL be dropped and not counted.
REQ-032 SHALL drive mem_addr = l1_wr_addr in L1_RUN, l2_rd_addr in L2_RUN when l2_sel_mem=1, and 0 otherwise.
REQ-033 SHALL assert busy in every state except IDLE and ERROR.
REQ-034 SHALL ignore l1_done outside L1_RUN and l2_done outside L2_RUN.

Reset
REQ-035 SHALL, on rst=0 (asynchronous, active-low), force IDLE, clear ofm_count and the timeout counter, and drive all outputs to 0 immediately.
REQ-036 SHALL, on rst=0 mid-run, abandon the run; after release the block SHALL stay in IDLE until a new start.

Verification
REQ-037 SHALL be verified by a nominal run: start; 172 writes; l1_done; l2_done -> l1_start pulse at cycle 1, l2_start pulse one cycle after l1_done, done pulse one cycle after l2_done, error=0.
REQ-038 SHALL be verified by a short run: 171 writes, then l1_done -> ERROR, error=1, ofm_count=171, l2_start never asserted.
REQ-039 SHALL be verified by a coincident final write: 172nd write in the same cycle as l1_done -> L2_START, ofm_count=172.
REQ-040 SHALL be verified by timeout: TIMEOUT_CYCLES=8 with l2_done withheld -> error=1 after 8 L2_RUN cycles; then start -> error=0 and l1_start pulse.
REQ-041 SHALL be verified by arbitration: l1_ofm_wr_en=1 in L2_RUN -> mem_wr_en=0; l2_sel_mem=1 with l2_rd_addr=0x2A -> mem_addr=0x2A and mem_owner=1.
REQ-042 SHALL be verified by reset mid-run: rst=0 during L1_RUN at ofm_count=50 -> outputs 0 immediately; after release, IDLE with busy=0 and ofm_count=0.
